// File: rtl/mult32_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encodings and the default operand / counter widths.
package mult32_seq_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/and32.sv
// 32-bit bitwise AND used to gate the multiplicand with the current
// multiplier bit, forming one partial product per iteration.
module and32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_out
);

    assign o_out = i_a & i_b;

endmodule

// File: rtl/mult32_seq.sv
// Sequential 32x32 unsigned shift-add multiplier with a start/done handshake.
// One partial product is accumulated into {hi,lo} per BUSY cycle.
module mult32_seq
    import mult32_seq_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = MULT_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   w_pp;
    logic [WIDTH:0]     w_sum;
    logic               w_accept;
    logic               w_lastIter;

    // start is only honoured outside BUSY, so an in-flight product is never disturbed
    assign w_accept   = (r_state != BUSY) && start;
    assign w_lastIter = (r_count == CNT_W'(WIDTH - 1));

    and32 u_and32 (
        .i_a   (r_a),
        .i_b   ({WIDTH{r_lo[0]}}),
        .o_out (w_pp)
    );

    assign w_sum = {1'b0, r_hi} + {1'b0, w_pp};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start)      w_nextState = BUSY;
            BUSY:    if (w_lastIter) w_nextState = DONE;
            DONE:    if (start)      w_nextState = BUSY;
            default:                 w_nextState = IDLE;
        endcase
    end

    // The adder carry shifts into the top of hi, so nothing is lost across 32 steps
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_a     <= multiplicand;
            r_hi    <= '0;
            r_lo    <= multiplier;
            r_count <= '0;
        end else if (r_state == BUSY) begin
            {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
            r_count      <= r_count + CNT_W'(1);
        end
    end

    assign busy    = (r_state == BUSY);
    assign done    = (r_state == DONE);
    assign product = {r_hi, r_lo};

endmodule
